// File: rtl/marquee_seq_ctrl.sv
// Sequencer for the rotating-ID display shifter: turns one-cycle key events
// into enable, direction, step and reload controls for the nibble-rotation
// datapath. Owns the step-rate prescaler, the revolution position counter
// and the bounce (auto-reverse) logic.
module marquee_seq_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BASE_RATE_HZ = 1,
  parameter int SPEED_LEVELS = 4,
  parameter int NUM_DIGITS   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_stop_i,
  input  logic                            dir_toggle_i,
  input  logic                            speed_up_i,
  input  logic                            speed_dn_i,
  input  logic                            bounce_en_i,
  input  logic                            reload_i,
  output logic                            en_out,
  output logic                            dir_out,
  output logic                            step_out,
  output logic                            load_out,
  output logic [1:0]                      state_out,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed_out,
  output logic [$clog2(NUM_DIGITS)-1:0]   pos_out
);

  localparam int SW   = $clog2(SPEED_LEVELS);
  localparam int PW   = $clog2(NUM_DIGITS);
  localparam int DIV0 = CLK_FREQ / BASE_RATE_HZ;
  localparam int CW   = $clog2(DIV0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LOAD  = 2'b11
  } state_t;

  state_t          st;
  state_t          st_nxt;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   spd_nxt;
  logic            spd_chg;
  logic            tick_term;
  logic            step_nxt;
  logic            pos_wrap;

  // Terminal prescaler value (DIV-1) for a given speed level.
  function automatic logic [CW-1:0] term_of(input logic [SW-1:0] lvl);
    int unsigned d;
    d = int'(CLK_FREQ) / (int'(BASE_RATE_HZ) << lvl);
    return CW'(d - 1);
  endfunction

  assign state_out = st;

  // Next state, speed request resolution and step decision.
  // The prescaler advances in every cycle whose next state is RUN, so the
  // cycle carrying start_stop_i already counts; this gives the first step
  // exactly DIV cycles after the start event and an immediate step when
  // resuming from a pause frozen at the terminal count.
  always_comb begin
    st_nxt = st;
    if (reload_i) begin
      st_nxt = S_LOAD;
    end else begin
      case (st)
        S_IDLE:  if (start_stop_i) st_nxt = S_RUN;
        S_RUN:   if (start_stop_i) st_nxt = S_PAUSE;
        S_PAUSE: if (start_stop_i) st_nxt = S_RUN;
        default: st_nxt = S_IDLE;
      endcase
    end

    spd_nxt = speed_out;
    if (speed_up_i && !speed_dn_i && speed_out != SW'(SPEED_LEVELS - 1))
      spd_nxt = speed_out + 1'b1;
    else if (speed_dn_i && !speed_up_i && speed_out != '0)
      spd_nxt = speed_out - 1'b1;
    spd_chg = (spd_nxt != speed_out);

    tick_term = (cnt == term_of(speed_out));
    step_nxt  = (st_nxt == S_RUN) && !spd_chg && tick_term;
    pos_wrap  = step_nxt && (pos_out == PW'(NUM_DIGITS - 1));
  end

  // Registered state, prescaler, position and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      cnt       <= '0;
      en_out    <= 1'b0;
      dir_out   <= 1'b1;
      step_out  <= 1'b0;
      load_out  <= 1'b0;
      speed_out <= '0;
      pos_out   <= '0;
    end else begin
      st        <= st_nxt;
      en_out    <= (st_nxt == S_RUN);
      load_out  <= (st_nxt == S_LOAD);
      step_out  <= step_nxt;
      speed_out <= spd_nxt;
      dir_out   <= dir_out ^ dir_toggle_i ^ (bounce_en_i & pos_wrap);
      if (st_nxt == S_LOAD) begin
        cnt     <= '0;
        pos_out <= '0;
      end else begin
        if (spd_chg)
          cnt <= '0;
        else if (st_nxt == S_RUN)
          cnt <= tick_term ? '0 : cnt + 1'b1;
        if (step_nxt)
          pos_out <= pos_wrap ? '0 : pos_out + 1'b1;
      end
    end
  end

endmodule
